// File: rtl/e_mdu.sv
// e_mdu -- execute-stage multiply/divide unit.
//
// Runs MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency and owns the
// HI/LO registers. It also serves MTHI/MTLO writes and MFHI/MFLO reads. The
// busy flag lets the hazard unit stall D-stage MDU instructions.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   E_MDU_op     0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI,8 MFLO
//   E_MDU_start  one-cycle start pulse for ops 1-4
//   E_rs_val     rs operand (dividend / multiplicand / MT source)
//   E_rt_val     rt operand (divisor / multiplier)
//   E_MDU_busy   registered; high while an operation is in flight
//   E_MDU_out    HI for MFHI, LO for MFLO, else 0 (combinational)
//   HI_out       current HI register
//   LO_out       current LO register
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_op,
  input  logic        E_MDU_start,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  output logic        E_MDU_busy,
  output logic [31:0] E_MDU_out,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   rs_q, rs_d;
  logic [31:0]   rt_q, rt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  // Arithmetic always works on the latched operands.
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        rt_safe;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic [31:0]        div_lo, div_hi;
  logic               div_ovf;
  logic               arith_op;

  assign prod_s = $signed({{32{rs_q[31]}}, rs_q}) * $signed({{32{rt_q[31]}}, rt_q});
  assign prod_u = {32'd0, rs_q} * {32'd0, rt_q};

  // A zero divisor never writes back; substituting 1 keeps the dividers defined.
  assign rt_safe = (rt_q == 32'd0) ? 32'd1 : rt_q;
  assign quot_s  = $signed(rs_q) / $signed(rt_safe);
  assign rem_s   = $signed(rs_q) % $signed(rt_safe);
  assign quot_u  = rs_q / rt_safe;
  assign rem_u   = rs_q % rt_safe;

  // INT_MIN / -1 overflows; pin the result rather than trusting the operator.
  assign div_ovf = (rs_q == 32'h8000_0000) && (rt_q == 32'hFFFF_FFFF);
  assign div_lo  = div_ovf ? 32'h8000_0000 : quot_s;
  assign div_hi  = div_ovf ? 32'd0 : rem_s;

  assign arith_op = (E_MDU_op >= OP_MULT) && (E_MDU_op <= OP_DIVU);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (E_MDU_start && arith_op) begin
          op_d    = E_MDU_op;
          rs_d    = E_rs_val;
          rt_d    = E_rt_val;
          cnt_d   = (E_MDU_op == OP_MULT || E_MDU_op == OP_MULTU) ?
                    CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          state_d = RUN;
          busy_d  = 1'b1;
        end else if (!E_MDU_start) begin
          if (E_MDU_op == OP_MTHI) hi_d = E_rs_val;
          if (E_MDU_op == OP_MTLO) lo_d = E_rs_val;
        end
      end
      RUN: begin
        // Anything arriving on the inputs while running is ignored.
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV:   if (rt_q != 32'd0) begin hi_d = div_hi; lo_d = div_lo; end
            OP_DIVU:  if (rt_q != 32'd0) begin hi_d = rem_u;  lo_d = quot_u; end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign E_MDU_busy = busy_q;
  assign HI_out     = hi_q;
  assign LO_out     = lo_q;
  assign E_MDU_out  = (E_MDU_op == OP_MFHI) ? hi_q :
                      (E_MDU_op == OP_MFLO) ? lo_q : 32'd0;

endmodule
